// File: rtl/cnn_mem_pkg.sv
// cnn_mem_pkg: shared BRAM geometry constants and the ifmap reader state encoding
package cnn_mem_pkg;
    localparam int BRAM_DATA_W = 32;
    localparam int BRAM_ADDR_W = 32;
    localparam int BRAM_WE_W   = 4;
    localparam int WORD_STRIDE = 4;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock return buffer with a zeroed head while empty
module sync_fifo
    import cnn_mem_pkg::*;
#(
    parameter int DATA_W = BRAM_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ifmap_bram_reader.sv
// ifmap_bram_reader: streams a contiguous BRAM block onto a valid/ready stream
module ifmap_bram_reader
    import cnn_mem_pkg::*;
#(
    parameter int DATA_W      = BRAM_DATA_W,
    parameter int ADDR_W      = BRAM_ADDR_W,
    parameter int LEN_W       = 16,
    parameter int ADDR_STRIDE = WORD_STRIDE,
    parameter int READ_LAT    = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     num_words,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    bram_addr,
    output logic                 bram_en,
    output logic [BRAM_WE_W-1:0] bram_we,
    output logic [DATA_W-1:0]    bram_din,
    input  logic [DATA_W-1:0]    bram_dout,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_valid,
    input  logic                 m_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    rd_state_t state;
    logic [LEN_W-1:0] num_q, issued, accepted, accepted_nx;
    logic [READ_LAT-1:0] pipe;
    logic [READ_LAT:0] pipe_ext;
    logic [CW-1:0] fifo_count, inflight;
    logic fifo_full, fifo_empty, push, pop;
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) inflight = inflight + CW'(pipe[i]);
    end
    // credit covers every read not yet popped, so the FIFO can never overflow
    assign bram_en     = (state == READ) && ((fifo_count + inflight) < CW'(FIFO_DEPTH));
    assign bram_we     = '0;
    assign bram_din    = '0;
    assign pipe_ext    = {pipe, bram_en};
    assign push        = pipe[READ_LAT-1];
    assign m_valid     = ~fifo_empty;
    assign pop         = m_valid & m_ready;
    assign accepted_nx = accepted + LEN_W'(pop);
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bram_dout),
        .dout  (m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bram_addr <= '0;
            num_q     <= '0;
            issued    <= '0;
            accepted  <= '0;
            pipe      <= '0;
        end else begin
            done <= 1'b0;
            pipe <= pipe_ext[READ_LAT-1:0];
            if (bram_en) begin
                bram_addr <= bram_addr + ADDR_W'(ADDR_STRIDE);
                issued    <= issued + 1'b1;
            end
            if (pop) accepted <= accepted_nx;
            case (state)
                IDLE: if (start) begin
                    bram_addr <= base_addr;
                    num_q     <= num_words;
                    issued    <= '0;
                    accepted  <= '0;
                    busy      <= num_words != '0;
                    done      <= num_words == '0;
                    state     <= num_words == '0 ? DONE : READ;
                end
                READ:  if (bram_en && issued + 1'b1 == num_q) state <= DRAIN;
                DRAIN: if (pop && accepted_nx == num_q) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));
endmodule

// File: tb/tb_ifmap_bram_reader.sv
// tb_ifmap_bram_reader: directed transfers checked against a queue-based stream model
module tb_ifmap_bram_reader;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [31:0] base_addr = 0;
    logic [15:0] num_words = 0;
    logic        busy, done, bram_en, m_valid;
    logic        m_ready = 1;
    logic [31:0] bram_addr, bram_din, m_data;
    logic [31:0] bram_dout = 0;
    logic [3:0]  bram_we;

    ifmap_bram_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
        .bram_din(bram_din), .bram_dout(bram_dout), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // BRAM port B: word i holds i*3, one cycle read latency
    always @(posedge clk) if (bram_en) bram_dout <= (bram_addr >> 2) * 3;

    int n_checks = 0, n_errors = 0, npops = 0, outstanding = 0;
    logic [31:0] addr_q[$], data_q[$], addr_log[$], data_log[$];
    logic m_act = 0, m_due = 0, prev_stall = 0;
    logic [31:0] prev_data = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic act_n, due_n;
        if (rst) begin
            addr_q.delete(); data_q.delete();
            m_act = 0; m_due = 0; prev_stall = 0; outstanding = 0;
        end else begin
            act_n = m_act;
            due_n = 1'b0;
            chk("done", {31'b0, done}, {31'b0, m_due});
            chk("busy", {31'b0, busy}, {31'b0, m_act});
            chk("we_din", {bram_we, bram_din[27:0]}, 32'h0);
            if (bram_en) begin
                if (addr_q.size() == 0) chk("spurious_en", 32'd1, 32'd0);
                else chk("addr", bram_addr, addr_q.pop_front());
                chk("credit", {31'b0, outstanding < 4}, 32'd1);
                addr_log.push_back(bram_addr);
                outstanding++;
            end
            if (prev_stall) begin
                chk("stall_valid", {31'b0, m_valid}, 32'd1);
                chk("stall_data", m_data, prev_data);
            end
            if (m_valid && data_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
            else if (m_valid && m_ready) begin
                chk("data", m_data, data_q.pop_front());
                data_log.push_back(m_data);
                outstanding--;
                npops++;
                if (data_q.size() == 0 && m_act) begin act_n = 0; due_n = 1; end
            end
            if (start && !m_act && !m_due) begin
                if (num_words == 0) due_n = 1;
                else act_n = 1;
                for (int k = 0; k < int'(num_words); k++) begin
                    logic [31:0] a;
                    a = base_addr + 32'(k) * 4;
                    addr_q.push_back(a);
                    data_q.push_back((a >> 2) * 3);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            m_act = act_n;
            m_due = due_n;
        end
    end

    task automatic go(input logic [31:0] base, input logic [15:0] num, input int mode,
                      output int t_done, output int t_valid);
        addr_log.delete(); data_log.delete();
        base_addr = base; num_words = num; start = 1; m_ready = 1;
        t_done = -1; t_valid = -1;
        for (int n = 1; n <= 500; n++) begin
            @(posedge clk); #1;
            start = (mode == 2 && n == 3);
            if (start) begin base_addr = 32'h800; num_words = 5; end
            m_ready = (mode == 1) ? (n % 4 == 0 || n % 4 == 1) : 1'b1;
            if (m_valid && t_valid < 0) t_valid = n;
            if (done) begin t_done = n; break; end
        end
        start = 0; m_ready = 1;
        if (t_done < 0) chk("timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk(nm, {busy, done, bram_en, m_valid, 28'b0}, 32'h0);
        chk({nm, "_addr"}, bram_addr, 32'h0);
        chk({nm, "_mdata"}, m_data, 32'h0);
    endtask

    initial begin
        int td, tv, p0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_reset_outputs("reset");

        go(32'h100, 16'd8, 0, td, tv);
        chk("t1_count", data_log.size(), 32'd8);
        chk("t1_addr0", addr_log[0], 32'h100);
        chk("t1_addr7", addr_log[7], 32'h11C);
        chk("t1_data0", data_log[0], 32'hC0);
        chk("t1_data7", data_log[7], 32'hD5);
        chk("t1_first_valid", tv, 32'd3);
        chk("t1_done_at", td, 32'd11);

        go(32'h40, 16'd16, 1, td, tv);
        chk("t2_count", data_log.size(), 32'd16);
        chk("t2_data15", data_log[15], 32'h5D);

        go(32'h300, 16'd0, 0, td, tv);
        chk("t3_done_at", td, 32'd1);
        chk("t3_no_traffic", addr_log.size() + data_log.size() + (tv >= 0 ? 1 : 0), 32'd0);

        go(32'hFFFF_FFF8, 16'd4, 0, td, tv);
        chk("t4_addr0", addr_log[0], 32'hFFFF_FFF8);
        chk("t4_addr1", addr_log[1], 32'hFFFF_FFFC);
        chk("t4_addr2", addr_log[2], 32'h0000_0000);
        chk("t4_addr3", addr_log[3], 32'h0000_0004);

        base_addr = 0; num_words = 32; start = 1;
        @(posedge clk); #1 start = 0;
        p0 = npops;
        for (int n = 0; n < 100 && npops - p0 < 4; n++) begin
            @(posedge clk); #1;
        end
        chk("t5_reached_4", npops - p0, 32'd4);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        chk_reset_outputs("t5_reset");
        go(32'h0, 16'd2, 0, td, tv);
        chk("t5_count", data_log.size(), 32'd2);
        chk("t5_data0", data_log[0], 32'h0);
        chk("t5_data1", data_log[1], 32'h3);

        go(32'h200, 16'd8, 2, td, tv);
        chk("t6_count", data_log.size(), 32'd8);
        chk("t6_data0", data_log[0], 32'h180);
        chk("t6_addr7", addr_log[7], 32'h21C);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
